// File: rtl/pong_score_keeper.sv
// Pong match score keeper: rally sequencing (serve delay, play, game over)
// and per-player two-digit BCD scores for downstream 7-segment decoders.
module pong_score_keeper #(
    parameter int unsigned WIN_SCORE   = 11,
    parameter int unsigned SERVE_DELAY = 50_000_000,
    parameter int unsigned BLANK_LEAD  = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       point_p1,
    input  logic       point_p2,
    input  logic       new_game,
    output logic [3:0] p1_tens,
    output logic [3:0] p1_ones,
    output logic [3:0] p2_tens,
    output logic [3:0] p2_ones,
    output logic       serve_ready,
    output logic       game_over,
    output logic [1:0] winner
);

    localparam logic [6:0]  WinScore  = 7'(WIN_SCORE);
    localparam logic [31:0] CntLoad   = 32'(SERVE_DELAY - 1);
    localparam logic        BlankLead = (BLANK_LEAD != 0);

    typedef enum logic [1:0] {
        StServeWait = 2'd0,
        StPlay      = 2'd1,
        StGameOver  = 2'd2
    } state_e;

    // Scores are held as {tens, ones} BCD pairs.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        if (v[3:0] == 4'd9) begin
            return {v[7:4] + 4'd1, 4'd0};
        end
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    function automatic logic [6:0] bcd_to_bin(input logic [7:0] v);
        return {3'b000, v[7:4]} * 7'd10 + {3'b000, v[3:0]};
    endfunction

    function automatic logic [3:0] tens_disp(input logic [3:0] t);
        return (BlankLead && (t == 4'd0)) ? 4'hF : t;
    endfunction

    state_e      r_state;
    state_e      w_state_d;
    logic [31:0] r_cnt;
    logic [31:0] w_cnt_d;
    logic        r_prev1;
    logic        r_prev2;
    logic [7:0]  r_p1_score;
    logic [7:0]  r_p2_score;
    logic [7:0]  w_p1_score_d;
    logic [7:0]  w_p2_score_d;
    logic [1:0]  r_winner;
    logic [1:0]  w_winner_d;

    logic [3:0]  r_p1_tens_out;
    logic [3:0]  r_p1_ones_out;
    logic [3:0]  r_p2_tens_out;
    logic [3:0]  r_p2_ones_out;
    logic        r_serve_ready;
    logic        r_game_over;
    logic [1:0]  r_winner_out;

    logic        w_ev1;
    logic        w_ev2;
    logic [7:0]  w_p1_inc;
    logic [7:0]  w_p2_inc;
    logic        w_p1_win;
    logic        w_p2_win;

    assign w_ev1    = point_p1 & ~r_prev1;
    assign w_ev2    = point_p2 & ~r_prev2;
    assign w_p1_inc = bcd_inc(r_p1_score);
    assign w_p2_inc = bcd_inc(r_p2_score);
    assign w_p1_win = (bcd_to_bin(w_p1_inc) == WinScore);
    assign w_p2_win = (bcd_to_bin(w_p2_inc) == WinScore);

    always_comb begin
        w_state_d    = r_state;
        w_cnt_d      = r_cnt;
        w_p1_score_d = r_p1_score;
        w_p2_score_d = r_p2_score;
        w_winner_d   = r_winner;

        if (new_game) begin
            w_state_d    = StServeWait;
            w_cnt_d      = CntLoad;
            w_p1_score_d = 8'h00;
            w_p2_score_d = 8'h00;
            w_winner_d   = 2'b00;
        end else begin
            unique case (r_state)
                StServeWait: begin
                    if (r_cnt == 32'd0) begin
                        w_state_d = StPlay;
                    end else begin
                        w_cnt_d = r_cnt - 32'd1;
                    end
                end
                StPlay: begin
                    // Simultaneous goals cancel out and play continues.
                    if (w_ev1 && !w_ev2) begin
                        w_p1_score_d = w_p1_inc;
                        if (w_p1_win) begin
                            w_state_d  = StGameOver;
                            w_winner_d = 2'b01;
                        end else begin
                            w_state_d = StServeWait;
                            w_cnt_d   = CntLoad;
                        end
                    end else if (w_ev2 && !w_ev1) begin
                        w_p2_score_d = w_p2_inc;
                        if (w_p2_win) begin
                            w_state_d  = StGameOver;
                            w_winner_d = 2'b10;
                        end else begin
                            w_state_d = StServeWait;
                            w_cnt_d   = CntLoad;
                        end
                    end
                end
                StGameOver: begin
                    w_state_d = StGameOver;
                end
                default: begin
                    w_state_d = StServeWait;
                    w_cnt_d   = CntLoad;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= StServeWait;
            r_cnt      <= CntLoad;
            r_prev1    <= 1'b0;
            r_prev2    <= 1'b0;
            r_p1_score <= 8'h00;
            r_p2_score <= 8'h00;
            r_winner   <= 2'b00;
        end else begin
            r_state    <= w_state_d;
            r_cnt      <= w_cnt_d;
            r_prev1    <= point_p1;
            r_prev2    <= point_p2;
            r_p1_score <= w_p1_score_d;
            r_p2_score <= w_p2_score_d;
            r_winner   <= w_winner_d;
        end
    end

    // Output flops load from next-state values so they track the state register exactly.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_p1_tens_out <= tens_disp(4'd0);
            r_p1_ones_out <= 4'd0;
            r_p2_tens_out <= tens_disp(4'd0);
            r_p2_ones_out <= 4'd0;
            r_serve_ready <= 1'b0;
            r_game_over   <= 1'b0;
            r_winner_out  <= 2'b00;
        end else begin
            r_p1_tens_out <= tens_disp(w_p1_score_d[7:4]);
            r_p1_ones_out <= w_p1_score_d[3:0];
            r_p2_tens_out <= tens_disp(w_p2_score_d[7:4]);
            r_p2_ones_out <= w_p2_score_d[3:0];
            r_serve_ready <= (w_state_d == StPlay);
            r_game_over   <= (w_state_d == StGameOver);
            r_winner_out  <= w_winner_d;
        end
    end

    assign p1_tens     = r_p1_tens_out;
    assign p1_ones     = r_p1_ones_out;
    assign p2_tens     = r_p2_tens_out;
    assign p2_ones     = r_p2_ones_out;
    assign serve_ready = r_serve_ready;
    assign game_over   = r_game_over;
    assign winner      = r_winner_out;

endmodule
